// File: rtl/opp_packet_filter.sv
// Opponent packet filter: validates received opponent-state packets, tracks link
// liveness with a timeout, and confirms remote reset requests over several packets.
module opp_packet_filter #(
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int RESET_CONFIRM  = 3,
  parameter int COORD_MAX      = 1023,
  parameter int DIR_MAX        = 359
) (
  input  logic        clk_in,
  input  logic        rst_in_n,
  input  logic        axiov,
  input  logic [43:0] axiod,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_valid,
  output logic        link_up,
  output logic        opp_reset_req,
  output logic [7:0]  drop_count
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int RCW = $clog2(RESET_CONFIRM + 1);
  localparam logic [TCW-1:0] T_LAST  = TCW'(TIMEOUT_CYCLES - 1);
  localparam logic [RCW-1:0] RC_LAST = RCW'(RESET_CONFIRM - 1);

  typedef enum logic {LINK_DOWN, LINK_UP} state_t;

  state_t           state;
  logic [TCW-1:0]   tmo_cnt;
  logic [RCW-1:0]   rc_cnt;
  logic [43:0]      last_pkt;

  logic [10:0] pkt_x, pkt_y;
  logic [8:0]  pkt_dir;
  logic [2:0]  pkt_game;
  logic        pkt_flag;
  logic        accept, is_new;

  assign pkt_x    = axiod[43:33];
  assign pkt_y    = axiod[31:21];
  assign pkt_dir  = axiod[19:11];
  assign pkt_game = axiod[7:5];
  assign pkt_flag = axiod[3];

  assign accept = axiov && (axiod != '0) && (int'(pkt_x) <= COORD_MAX) &&
                  (int'(pkt_y) <= COORD_MAX) && (int'(pkt_dir) <= DIR_MAX);
  // Repeats of the last accepted packet keep the link alive without re-announcing it
  assign is_new = (axiod != last_pkt);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state         <= LINK_DOWN;
      link_up       <= 1'b0;
      tmo_cnt       <= '0;
      rc_cnt        <= '0;
      last_pkt      <= '0;
      opp_x         <= '0;
      opp_y         <= '0;
      opp_dir       <= '0;
      opp_game      <= '0;
      opp_valid     <= 1'b0;
      opp_reset_req <= 1'b0;
      drop_count    <= '0;
    end else begin
      opp_valid     <= 1'b0;
      opp_reset_req <= 1'b0;
      if (axiov && !accept && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      if (accept) begin
        state   <= LINK_UP;
        link_up <= 1'b1;
        tmo_cnt <= '0;
        if (is_new) begin
          opp_x     <= pkt_x;
          opp_y     <= pkt_y;
          opp_dir   <= pkt_dir;
          opp_game  <= pkt_game;
          last_pkt  <= axiod;
          opp_valid <= 1'b1;
        end
        if (!pkt_flag)
          rc_cnt <= '0;
        else if (rc_cnt == RC_LAST) begin
          rc_cnt        <= '0;
          opp_reset_req <= 1'b1;
        end else
          rc_cnt <= rc_cnt + 1'b1;
      end else if (state == LINK_UP) begin
        // Link loss keeps last position but reports no game in progress
        if (tmo_cnt == T_LAST) begin
          state    <= LINK_DOWN;
          link_up  <= 1'b0;
          tmo_cnt  <= '0;
          opp_game <= '0;
          rc_cnt   <= '0;
        end else
          tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_opp_packet_filter.sv
// Randomized and directed bench for opp_packet_filter against an age/run based model.
module tb_opp_packet_filter;
  localparam int T  = 16;
  localparam int RC = 3;

  logic        clk_in = 1'b0;
  logic        rst_in_n;
  logic        axiov;
  logic [43:0] axiod;
  logic [10:0] opp_x, opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_valid, link_up, opp_reset_req;
  logic [7:0]  drop_count;

  opp_packet_filter #(.TIMEOUT_CYCLES(T), .RESET_CONFIRM(RC),
                      .COORD_MAX(1023), .DIR_MAX(359)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .axiov(axiov), .axiod(axiod),
    .opp_x(opp_x), .opp_y(opp_y), .opp_dir(opp_dir), .opp_game(opp_game),
    .opp_valid(opp_valid), .link_up(link_up), .opp_reset_req(opp_reset_req),
    .drop_count(drop_count));

  always #5 clk_in = ~clk_in;

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // model: age = idle edges since last accept (saturates at T), run = flagged accepts in a row
  int m_x, m_y, m_dir, m_game, m_drop, m_age, m_run;
  bit m_valid, m_req, m_seen;
  logic [43:0] m_last;

  task automatic m_reset();
    m_x = 0; m_y = 0; m_dir = 0; m_game = 0; m_drop = 0; m_age = 0; m_run = 0;
    m_valid = 0; m_req = 0; m_seen = 0; m_last = '0;
  endtask

  task automatic m_step(input bit v, input logic [43:0] d);
    bit acc;
    acc = v && d != 0 && int'(d[43:33]) <= 1023 && int'(d[31:21]) <= 1023 &&
          int'(d[19:11]) <= 359;
    m_valid = 0; m_req = 0;
    if (v && !acc && m_drop < 255) m_drop++;
    if (acc) begin
      if (d != m_last) begin
        m_x = int'(d[43:33]); m_y = int'(d[31:21]); m_dir = int'(d[19:11]);
        m_game = int'(d[7:5]); m_last = d; m_valid = 1;
      end
      m_age = 0; m_seen = 1;
      if (d[3]) begin
        m_run++;
        if (m_run == RC) begin m_req = 1; m_run = 0; end
      end else m_run = 0;
    end else if (m_seen && m_age < T) begin
      m_age++;
      if (m_age == T) begin m_game = 0; m_run = 0; end
    end
  endtask

  task automatic check_all();
    chk("opp_x", opp_x, m_x);
    chk("opp_y", opp_y, m_y);
    chk("opp_dir", opp_dir, m_dir);
    chk("opp_game", opp_game, m_game);
    chk("opp_valid", opp_valid, m_valid);
    chk("link_up", link_up, m_seen && m_age < T);
    chk("opp_reset_req", opp_reset_req, m_req);
    chk("drop_count", drop_count, m_drop);
  endtask

  // called at posedge+1; drives one cycle, then checks at next posedge+1
  task automatic cyc(input bit v, input logic [43:0] d);
    axiov = v; axiod = d;
    @(posedge clk_in);
    m_step(v, d);
    #1 check_all();
  endtask

  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int game, input int flag);
    logic [43:0] d;
    d = '0;
    d[43:33] = x[10:0]; d[31:21] = y[10:0]; d[19:11] = dir[8:0];
    d[7:5] = game[2:0]; d[3] = flag[0];
    return d;
  endfunction

  task automatic mid_reset();
    axiov = 0;
    #2 rst_in_n = 0;
    #1;
    chk("rst_x", opp_x, 0);       chk("rst_y", opp_y, 0);
    chk("rst_dir", opp_dir, 0);   chk("rst_game", opp_game, 0);
    chk("rst_valid", opp_valid, 0); chk("rst_link", link_up, 0);
    chk("rst_req", opp_reset_req, 0); chk("rst_drop", drop_count, 0);
    m_reset();
    @(posedge clk_in); #1 rst_in_n = 1;
  endtask

  int pulses;
  logic [43:0] last_sent, d;

  initial begin
    rst_in_n = 0; axiov = 0; axiod = '0;
    m_reset();
    repeat (3) @(posedge clk_in);
    #1 check_all();
    rst_in_n = 1;
    cyc(0, 44'hFFF_FFFF_FFFF);

    // basic accept
    cyc(1, mk(100, 200, 90, 2, 0));
    chk("r33_x", opp_x, 100); chk("r33_y", opp_y, 200);
    chk("r33_dir", opp_dir, 90); chk("r33_game", opp_game, 2);
    chk("r33_valid", opp_valid, 1); chk("r33_link", link_up, 1);
    cyc(0, '0);
    chk("r33_pulse_end", opp_valid, 0);

    // rejects and saturation
    cyc(1, '0); cyc(1, mk(1500, 5, 5, 1, 0)); cyc(1, mk(5, 5, 400, 1, 0));
    chk("r34_drop3", drop_count, 3); chk("r34_hold_x", opp_x, 100);
    repeat (257) cyc(1, mk(7, 2000, 1, 1, 0));
    chk("r34_drop_sat", drop_count, 255);

    // duplicate packet
    cyc(1, mk(300, 301, 10, 1, 0));
    cyc(1, mk(300, 301, 10, 1, 0));
    chk("r37_dup_valid", opp_valid, 0);

    // timeout
    cyc(1, mk(400, 401, 20, 3, 0));
    repeat (15) cyc(0, '0);
    chk("r35_link_pre", link_up, 1);
    cyc(0, '0);
    chk("r35_link_down", link_up, 0); chk("r35_game0", opp_game, 0);
    chk("r35_x_held", opp_x, 400);
    cyc(1, mk(410, 401, 20, 3, 0));
    repeat (15) cyc(0, '0);
    cyc(1, mk(411, 401, 20, 3, 0));
    repeat (1) cyc(0, '0);
    chk("r35_expiry_accept", link_up, 1);

    // reset confirm: 1,1,0,1,bad,1,1
    cyc(1, mk(1, 1, 1, 1, 0));
    pulses = 0;
    for (int i = 0; i < 7; i++) begin
      case (i)
        2:       cyc(1, mk(10 + i, 1, 1, 1, 0));
        4:       cyc(1, mk(1, 1, 999, 1, 1));
        default: cyc(1, mk(10 + i, 1, 1, 1, 1));
      endcase
      if (opp_reset_req) pulses++;
    end
    chk("r36_last_pulse", opp_reset_req, 1);
    chk("r36_pulses", pulses, 1);
    cyc(0, '0);

    mid_reset();
    cyc(0, '0);

    // randomized traffic
    last_sent = mk(5, 5, 5, 1, 1);
    for (int i = 0; i < 400; i++) begin
      int gap, r;
      gap = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 20) : $urandom_range(0, 2);
      repeat (gap) cyc(0, 44'({$urandom(), $urandom()}));
      r = $urandom_range(0, 15);
      if (r == 0) d = '0;
      else if (r < 3) d = last_sent;
      else begin
        d = mk($urandom_range(0, 1100), $urandom_range(0, 1100), $urandom_range(0, 380),
               $urandom_range(0, 7), ($urandom_range(0, 3) != 0) ? 1 : 0);
        d[2:0] = 3'($urandom_range(0, 7));
      end
      last_sent = d;
      cyc(1, d);
      if (i == 200) begin mid_reset(); cyc(0, '0); end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/opp_packet_filter.md
OPP_PACKET_FILTER -- requirements
Module: opp_packet_filter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 5000000: cycles with no accepted packet before link is declared down.
REQ-002 Parameter RESET_CONFIRM, default 3: consecutive accepted packets with reset flag needed to assert opp_reset_req.
REQ-003 Parameter COORD_MAX, default 1023: largest legal x/y value.
REQ-004 Parameter DIR_MAX, default 359: largest legal direction value.
REQ-005 clk_in  input  1  single clock (eth_refclk domain); all logic on rising edge.
REQ-006 rst_in_n  input  1  asynchronous, active-low reset.
REQ-007 axiov  input  1  packet-valid strobe from receive, one cycle per packet.
REQ-008 axiod  input  44  raw packet: x[43:33], y[31:21], dir[19:11], game[7:5], reset flag[3].
REQ-009 opp_x  output  11  last accepted opponent x.
REQ-010 opp_y  output  11  last accepted opponent y.
REQ-011 opp_dir  output  9  last accepted opponent direction.
REQ-012 opp_game  output  3  last accepted opponent game status.
REQ-013 opp_valid  output  1  one-cycle pulse when outputs update.
REQ-014 link_up  output  1  high while packets are arriving within timeout.
REQ-015 opp_reset_req  output  1  one-cycle pulse, confirmed remote reset request.
REQ-016 drop_count  output  8  saturating count of rejected packets.

Function
REQ-017 A packet is sampled only in a cycle with axiov=1; axiod is ignored otherwise.
REQ-018 Reject when axiod==0, x>COORD_MAX, y>COORD_MAX, or dir>DIR_MAX; all other packets are accepted.
REQ-019 A packet bit-identical to the last accepted packet is accepted (refreshes timeout, counts toward reset confirm) but does not pulse opp_valid.
REQ-020 On accept of a new packet, opp_x/y/dir/game load on the same edge and opp_valid pulses for exactly the following cycle (latency 1 from axiov).
REQ-021 On reject, outputs hold, opp_valid stays 0, drop_count increments by 1 and saturates at 255.
REQ-022 State machine LINK_DOWN / LINK_UP; link_up=1 exactly in LINK_UP.
REQ-023 LINK_DOWN -> LINK_UP on any accepted packet; timeout counter cleared.
REQ-024 In LINK_UP the timeout counter increments each cycle without an accepted packet and clears on accept; reaching TIMEOUT_CYCLES-1 moves to LINK_DOWN next edge.
REQ-025 Accept and timeout expiry in the same cycle: accept wins, stay LINK_UP, counter cleared.
REQ-026 Entering LINK_DOWN via timeout holds opp_x/y/dir and forces opp_game to 0.
REQ-027 Reset-confirm counter increments on each accepted packet with flag=1, clears on accepted packet with flag=0 or on entering LINK_DOWN; rejected packets leave it unchanged.
REQ-028 When the confirm counter reaches RESET_CONFIRM, opp_reset_req pulses one cycle and the counter clears; a new run of RESET_CONFIRM is needed for another pulse.
REQ-029 Timeout counter width = clog2(TIMEOUT_CYCLES)+1; no wrap is permitted.

Reset
REQ-030 rst_in_n=0 asynchronously forces: state LINK_DOWN, link_up=0, opp_x=opp_y=opp_dir=0, opp_game=0, opp_valid=0, opp_reset_req=0, drop_count=0, all internal counters and last-packet register 0.
REQ-031 Reset asserted mid-packet discards that packet; first packet after release is processed normally.
REQ-032 Reset release is synchronous to clk_in; no packet sampled on the release edge.

Verification
REQ-033 Valid packet x=100,y=200,dir=90,game=2 -> next cycle opp_x=100,opp_y=200,opp_dir=90,opp_game=2, opp_valid=1 one cycle, link_up=1.
REQ-034 Packets with axiod=0, x=1500, dir=400 -> outputs unchanged, opp_valid=0, drop_count=3; 260 bad packets -> drop_count=255.
REQ-035 TIMEOUT_CYCLES=16, one packet then idle -> link_up drops 16 cycles after accept, opp_game=0, opp_x held; packet on expiry cycle -> link_up stays 1.
REQ-036 RESET_CONFIRM=3: flags 1,1,0,1,1,1 -> single opp_reset_req pulse after sixth packet only; bad packet between flags does not break the run.
REQ-037 Same packet sent twice -> one opp_valid pulse; timeout refreshed by second.
REQ-038 rst_in_n pulsed low mid-operation between clock edges -> all outputs 0 immediately, drop_count 0, link_up 0.
